// File: rtl/conv3d_cfg_queue.sv
// conv3d_cfg_queue: config register decode, descriptor FIFO, prefetch and in-flight tracking
// Status readback returns the state after the sampling edge, so it is built from next-state values.
module conv3d_cfg_queue #(
   parameter int AW    = 30,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          config_ena,
   input  logic [5:0]    config_addr,
   input  logic [31:0]   config_data,
   input  logic          config_rd,
   output logic [31:0]   config_rdata,
   output logic          cfg_valid,
   input  logic          cfg_ready,
   output logic [AW-1:0] cfg_xbase,
   output logic [AW-1:0] cfg_ybase,
   output logic [AW-1:0] cfg_zbase,
   output logic [AW-1:0] cfg_xoffset,
   output logic [AW-1:0] cfg_yoffset,
   output logic [8:0]    cfg_width_in,
   output logic [8:0]    cfg_height_out,
   output logic [17:0]   cfg_length_in,
   output logic [17:0]   cfg_length_out,
   input  logic          cfg_done,
   output logic          cfg_prefetch,
   output logic [AW-1:0] cfg_waddr,
   output logic [7:0]    cfg_length_w,
   input  logic          cfg_prefetch_done
);
   localparam int PW = $clog2(DEPTH);
   localparam int DW = 5 * AW + 54;

   logic [AW-1:0] waddr, xbase, ybase, zbase, xoffset, yoffset;
   logic [7:0]    wlength;
   logic [8:0]    width_in, height_out;
   logic [17:0]   length_in, length_out;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   level, level_n;
   logic [7:0]    inflight, inflight_n, done_cnt, done_n;
   logic          pf_busy, pf_busy_n, err_ovf, err_ovf_n, err_sp, err_sp_n, err_pf, err_pf_n;
   logic          wr_run, wr_pf, clr_err, flush, pop, push, done_ok, pf_go;
   logic [31:0]   status_n, rd_fld, rd_msk, rdata_n;

   assign wr_run  = config_ena && config_addr == 6'd19 && config_data[0];
   assign wr_pf   = config_ena && config_addr == 6'd2 && config_data[0];
   assign clr_err = config_ena && config_addr == 6'd21 && config_data[0];
   assign flush   = config_ena && config_addr == 6'd21 && config_data[1];
   assign cfg_valid = level != '0;
   assign pop     = cfg_valid && cfg_ready && !flush;
   assign push    = wr_run && !flush && (level != (PW+1)'(DEPTH) || pop);
   assign done_ok = cfg_done && (inflight != 8'd0 || pop);
   // a coinciding prefetch_done frees the engine before the new request is judged
   assign pf_go   = wr_pf && (!pf_busy || cfg_prefetch_done);

   assign head = cfg_valid ? mem[rd_ptr] : '0;
   assign {cfg_xbase, cfg_ybase, cfg_zbase, cfg_xoffset, cfg_yoffset,
           cfg_width_in, cfg_height_out, cfg_length_in, cfg_length_out} = head;
   assign cfg_waddr    = waddr;
   assign cfg_length_w = wlength;

   always_comb begin
      level_n    = flush ? '0 : level + (PW+1)'(push) - (PW+1)'(pop);
      inflight_n = (pop && !done_ok) ? (inflight == 8'hFF ? inflight : inflight + 8'd1)
                 : (!pop && done_ok) ? inflight - 8'd1 : inflight;
      done_n     = clr_err ? 8'd0 : done_cnt + 8'(done_ok);
      pf_busy_n  = pf_go || (pf_busy && !cfg_prefetch_done);
      err_ovf_n  = (err_ovf && !clr_err) || (wr_run && !flush && !push);
      err_sp_n   = (err_sp && !clr_err) || (cfg_done && !done_ok);
      err_pf_n   = (err_pf && !clr_err) || (wr_pf && !pf_go);
      status_n   = {done_n, 3'b000, err_pf_n, err_sp_n, err_ovf_n, pf_busy_n,
                    level_n != '0 || inflight_n != 8'd0, inflight_n, 8'(level_n)};
   end

   always_comb begin
      rd_fld = '0;
      rd_msk = '0;
      case (config_addr)
         6'd0:  begin rd_fld = 32'(waddr);      rd_msk = 32'({AW{1'b1}}); end
         6'd1:  begin rd_fld = 32'(wlength);    rd_msk = 32'h0000_00FF;   end
         6'd10: begin rd_fld = 32'(xbase);      rd_msk = 32'({AW{1'b1}}); end
         6'd11: begin rd_fld = 32'(ybase);      rd_msk = 32'({AW{1'b1}}); end
         6'd12: begin rd_fld = 32'(zbase);      rd_msk = 32'({AW{1'b1}}); end
         6'd13: begin rd_fld = 32'(xoffset);    rd_msk = 32'({AW{1'b1}}); end
         6'd14: begin rd_fld = 32'(yoffset);    rd_msk = 32'({AW{1'b1}}); end
         6'd15: begin rd_fld = 32'(width_in);   rd_msk = 32'h0000_01FF;   end
         6'd16: begin rd_fld = 32'(height_out); rd_msk = 32'h0000_01FF;   end
         6'd17: begin rd_fld = 32'(length_in);  rd_msk = 32'h0003_FFFF;   end
         6'd18: begin rd_fld = 32'(length_out); rd_msk = 32'h0003_FFFF;   end
         default: ;
      endcase
      // a write to the same address this cycle is what the register holds after the edge
      rdata_n = config_addr == 6'd20 ? status_n : (config_ena ? config_data & rd_msk : rd_fld);
   end

   always_ff @(posedge clk)
      if (push)
         mem[wr_ptr] <= {xbase, ybase, zbase, xoffset, yoffset,
                         width_in, height_out, length_in, length_out};

   always_ff @(posedge clk) begin
      if (rst) begin
         waddr        <= '0;
         wlength      <= '0;
         xbase        <= '0;
         ybase        <= '0;
         zbase        <= '0;
         xoffset      <= '0;
         yoffset      <= '0;
         width_in     <= '0;
         height_out   <= '0;
         length_in    <= '0;
         length_out   <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         inflight     <= '0;
         done_cnt     <= '0;
         pf_busy      <= 1'b0;
         err_ovf      <= 1'b0;
         err_sp       <= 1'b0;
         err_pf       <= 1'b0;
         cfg_prefetch <= 1'b0;
         config_rdata <= '0;
      end else begin
         if (config_ena)
            case (config_addr)
               6'd0:  waddr      <= config_data[AW-1:0];
               6'd1:  wlength    <= config_data[7:0];
               6'd10: xbase      <= config_data[AW-1:0];
               6'd11: ybase      <= config_data[AW-1:0];
               6'd12: zbase      <= config_data[AW-1:0];
               6'd13: xoffset    <= config_data[AW-1:0];
               6'd14: yoffset    <= config_data[AW-1:0];
               6'd15: width_in   <= config_data[8:0];
               6'd16: height_out <= config_data[8:0];
               6'd17: length_in  <= config_data[17:0];
               6'd18: length_out <= config_data[17:0];
               default: ;
            endcase
         wr_ptr       <= wr_ptr + PW'(push);
         rd_ptr       <= flush ? wr_ptr : rd_ptr + PW'(pop);
         level        <= level_n;
         inflight     <= inflight_n;
         done_cnt     <= done_n;
         pf_busy      <= pf_busy_n;
         err_ovf      <= err_ovf_n;
         err_sp       <= err_sp_n;
         err_pf       <= err_pf_n;
         cfg_prefetch <= pf_go;
         if (config_rd)
            config_rdata <= rdata_n;
      end
   end
endmodule

// File: doc/conv3d_cfg_queue.md
# conv3d_cfg_queue

Parametrised configuration front-end for the conv3d engine. It decodes the 32-bit configuration write bus into shadow registers and snapshots them into a DEPTH-entry descriptor queue on each RUN command. The engine consumes descriptors over a valid/ready handshake. Weight-prefetch control, in-flight/done tracking, sticky error flags and a registered status readback let software queue layers back-to-back without waiting for each layer to finish.

## Interface
- AW, 30, address field width (1..32)
- DEPTH, 4, descriptor queue depth; power of two, 2..128
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- config_ena  in  1  write strobe
- config_addr  in  6  register address
- config_data  in  32  write data
- config_rd  in  1  read strobe
- config_rdata  out  32  read data, registered
- cfg_valid  out  1  head descriptor valid
- cfg_ready  in  1  engine accepts head descriptor
- cfg_xbase/ybase/zbase/xoffset/yoffset  out  AW each  head descriptor fields
- cfg_width_in, cfg_height_out  out  9 each  head descriptor fields
- cfg_length_in, cfg_length_out  out  18 each  head descriptor fields
- cfg_done  in  1  engine finished one descriptor (1-cycle pulse)
- cfg_prefetch  out  1  one-cycle prefetch start pulse
- cfg_waddr  out  AW  weight address
- cfg_length_w  out  8  weight length
- cfg_prefetch_done  in  1  prefetch finished pulse

## Operation
- Write map (config_ena=1). Each field takes config_data LSBs truncated to its width.
  - 0 WADDR; 1 WLENGTH; 2 WPREFETCH.
  - 10 XBASE, 11 YBASE, 12 ZBASE, 13 XOFFSET, 14 YOFFSET.
  - 15 WIDTH_IN, 16 HEIGHT_OUT, 17 LENGTH_IN, 18 LENGTH_OUT.
  - 19 RUN; 21 CLEAR. All other addresses are ignored.
- Shadow registers hold their value until rewritten. They are not cleared on RUN, so only the changed fields need rewriting per layer.
- RUN with data[0]=1 pushes a snapshot of all nine shadow fields.
  - Queue not full, or full with a pop in the same cycle: push is accepted.
  - Otherwise: descriptor is dropped and err_overflow sets.
  - RUN with data[0]=0 has no effect.
- Queue is a FIFO.
  - cfg_valid = (level != 0); cfg_* fields always show the head entry.
  - Pop happens when cfg_valid & cfg_ready. cfg_ready while empty is ignored.
- In-flight counter (8 bit):
  - +1 on pop, -1 on cfg_done, unchanged when both occur in the same cycle.
  - cfg_done with in-flight = 0 and no simultaneous pop: ignored, err_spurious sets.
  - Saturates at 255.
- Done counter (8 bit) increments on each accepted cfg_done and wraps 255 -> 0.
- Prefetch:
  - WPREFETCH data[0]=1 while pf_busy=0: cfg_prefetch pulses next cycle and pf_busy sets.
  - WPREFETCH while pf_busy=1: no pulse, err_prefetch sets.
  - cfg_prefetch_done clears pf_busy. If it coincides with a WPREFETCH, the done is processed first, so the write is accepted.
  - cfg_waddr and cfg_length_w are direct shadow outputs.
- CLEAR:
  - data[0]=1 clears the three error flags and the done counter.
  - data[1]=1 flushes the queue (level -> 0). In-flight work is unaffected.
  - If a flush coincides with a pop, the flush wins.
- Status, read at address 20:
  - [7:0] queue level; [15:8] in-flight; [16] busy = cfg_valid | (in-flight != 0); [17] pf_busy.
  - [18] err_overflow, [19] err_spurious, [20] err_prefetch; [31:24] done counter.
- Shadow fields read back at their write addresses, zero-extended. Unmapped addresses read 0.

## Timing
- Reset value 0 for: every shadow register, queue level, pointers, both counters, all flags, config_rdata, cfg_valid, cfg_prefetch. Head fields read 0 while empty.
- Reset mid-operation discards queued descriptors, the in-flight count and any pending prefetch pulse.
- RUN written in cycle N: cfg_valid=1 in cycle N+1 when the queue was empty.
  - Fields come from the shadow values at the clock edge ending cycle N.
- Pop at edge N: the next entry is presented in cycle N+1. Back-to-back pops give one descriptor per cycle.
- Field write in cycle N is visible to a RUN in cycle N+1.
- config_rdata is valid the cycle after config_rd and holds until the next read.
- Status reflects state after the edge at which the read is sampled.
- cfg_prefetch is exactly one cycle wide.

## Test plan
- Reset, then read status (addr 20) -> 0x00000000; cfg_valid=0; cfg_prefetch=0; all cfg_* = 0.
- Write XBASE=0x100, LENGTH_IN=0x3FFFF, RUN=1 with cfg_ready=0 -> next cycle cfg_valid=1, cfg_xbase=0x100, cfg_length_in=0x3FFFF; status level=1, busy=1.
- DEPTH=4: five RUNs with cfg_ready=0 -> level=4, err_overflow=1. Then cfg_ready=1 -> four descriptors in order, one per cycle, cfg_valid=0 after. Three cfg_done pulses -> in-flight=1, done=3.
- Same cycle pop and cfg_done with in-flight=1 -> in-flight stays 1. cfg_done with in-flight=0 -> err_spurious=1, done unchanged. CLEAR data=1 -> errors 0, done 0.
- WPREFETCH=1 -> single-cycle cfg_prefetch, pf_busy=1. Second WPREFETCH -> no pulse, err_prefetch=1. cfg_prefetch_done coinciding with a third WPREFETCH -> pulse issued.
- Queue 3 entries, CLEAR data=2 -> cfg_valid=0 next cycle, in-flight unchanged. Assert rst mid-stream -> status 0 next cycle.
